// File: rtl/keccak_arbiter_pkg.sv
// Shared keccak definitions: core word width, digest width and arbiter FSM states.
package pkg_keccak;

    localparam int IN_BUF_SIZE  = 64;
    localparam int DIGEST_WIDTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_LAST,
        ST_WAIT,
        ST_RESP,
        ST_CLR
    } arb_state_t;

endpackage

// File: rtl/keccak_arbiter_if.sv
// Requester, response and core-side bundle of the keccak arbiter.
// slave = arbiter side, master = requesters/consumer/core side.
interface keccak_arbiter_if
    import pkg_keccak::*;
#(
    parameter int NUM_REQ = 2
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0][IN_BUF_SIZE-1:0] req_din;
    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_last;
    logic [NUM_REQ-1:0]                  req_ready;

    logic [DIGEST_WIDTH-1:0] resp_digest;
    logic [ID_W-1:0]         resp_id;
    logic                    resp_valid;
    logic                    resp_ready;
    logic                    resp_err;

    logic [IN_BUF_SIZE-1:0]  core_din;
    logic                    core_din_valid;
    logic                    core_last_block;
    logic                    core_reset;
    logic                    core_buffer_full;
    logic                    core_ready;
    logic                    core_dout_valid;
    logic [DIGEST_WIDTH-1:0] core_dout;

    modport slave (
        input  req_din, req_valid, req_last, resp_ready,
        input  core_buffer_full, core_ready, core_dout_valid, core_dout,
        output req_ready, resp_digest, resp_id, resp_valid, resp_err,
        output core_din, core_din_valid, core_last_block, core_reset
    );

    modport master (
        output req_din, req_valid, req_last, resp_ready,
        output core_buffer_full, core_ready, core_dout_valid, core_dout,
        input  req_ready, resp_digest, resp_id, resp_valid, resp_err,
        input  core_din, core_din_valid, core_last_block, core_reset
    );

endinterface

// File: rtl/keccak_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr, wrapping.
module keccak_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    grant_id
);

    int idx;

    // NOTE: every output gets a default before any branch so no path infers a latch.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        // Scan from the farthest offset down so the nearest valid requester wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (req_valid[idx[ID_W-1:0]]) begin
                found    = 1'b1;
                grant_id = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/keccak_arbiter.sv
// Round-robin scheduler sharing one keccak core between NUM_REQ message sources.
// Optional digest watchdog is built when KECCAK_ARB_TIMEOUT_EN is defined.
module keccak_arbiter
    import pkg_keccak::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic             clock,
    input logic             reset_n,
    keccak_arbiter_if.slave bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t              state, next_state;
    logic [ID_W-1:0]         grant_id, rr_ptr, pick_id;
    logic                    pick_found, grant_load, capture, abort_wait, din_valid, timeout_hit;
    logic [NUM_REQ-1:0]      ready_vec;
    logic [DIGEST_WIDTH-1:0] resp_digest_q;
    logic [ID_W-1:0]         resp_id_q;

    keccak_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .found     (pick_found),
        .grant_id  (pick_id)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state  = state;
        ready_vec   = '0;
        din_valid   = 1'b0;
        grant_load  = 1'b0;
        capture     = 1'b0;
        abort_wait  = 1'b0;
        bus.core_last_block = 1'b0;
        case (state)
            ST_IDLE: if (pick_found) begin
                grant_load = 1'b1;
                next_state = ST_FEED;
            end
            ST_FEED: begin
                ready_vec[grant_id] = ~bus.core_buffer_full;
                din_valid = bus.req_valid[grant_id] & ~bus.core_buffer_full;
                if (din_valid && bus.req_last[grant_id]) next_state = ST_LAST;
            end
            ST_LAST: begin
                bus.core_last_block = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (~bus.core_buffer_full & bus.core_ready & bus.core_dout_valid) begin
                    capture    = 1'b1;
                    next_state = ST_RESP;
                end else if (timeout_hit) begin
                    abort_wait = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: if (bus.resp_ready) next_state = ST_CLR;
            ST_CLR:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant_id      <= '0;
            rr_ptr        <= '0;
            resp_digest_q <= '0;
            resp_id_q     <= '0;
        end else begin
            if (grant_load) begin
                grant_id <= pick_id;
                rr_ptr   <= (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + ID_W'(1);
            end
            if (capture) begin
                resp_digest_q <= bus.core_dout;
                resp_id_q     <= grant_id;
            end else if (abort_wait) begin
                resp_digest_q <= '0;
                resp_id_q     <= grant_id;
            end
        end
    end

`ifdef KECCAK_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        resp_err_q;

    // Counter is zero on the first WAIT cycle and counts WAIT cycles thereafter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (state == ST_LAST)      wait_cnt <= '0;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + 16'd1;
            if (capture)         resp_err_q <= 1'b0;
            else if (abort_wait) resp_err_q <= 1'b1;
        end
    end

    assign timeout_hit  = (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign bus.resp_err = resp_err_q;
`else
    // Only the watchdog build consumes the timeout limit.
    localparam int timeout_unused = TIMEOUT_CYCLES;
    assign timeout_hit  = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready      = ready_vec;
    assign bus.core_din       = bus.req_din[grant_id];
    assign bus.core_din_valid = din_valid;
    assign bus.core_reset     = ~reset_n | (state == ST_CLR);
    assign bus.resp_valid     = (state == ST_RESP);
    assign bus.resp_digest    = resp_digest_q;
    assign bus.resp_id        = resp_id_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Self-checking bench for keccak_arbiter: directed scenarios with random data and an
// arithmetic round-robin reference; the timeout scenario runs when KECCAK_ARB_TIMEOUT_EN is set.
module tb_keccak_arbiter;
    import pkg_keccak::*;

    localparam int NUM_REQ = 2;
    localparam int TO      = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    keccak_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    keccak_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first active requester at or after the pointer, wrapping.
    function automatic int pick(input logic [NUM_REQ-1:0] act);
        for (int k = 0; k < NUM_REQ; k++)
            if (act[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic idle_inputs();
        bus.req_valid        = '0;
        bus.req_last         = '0;
        bus.req_din          = '0;
        bus.core_buffer_full = 1'b0;
        bus.core_ready       = 1'b1;
        bus.core_dout_valid  = 1'b0;
        bus.core_dout        = '0;
        bus.resp_ready       = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},   bus.req_ready, '0);
        check({tag, "_resp_valid"},  bus.resp_valid, 0);
        check({tag, "_resp_err"},    bus.resp_err, 0);
        check({tag, "_resp_digest"}, bus.resp_digest, 0);
        check({tag, "_resp_id"},     bus.resp_id, 0);
        check({tag, "_din_valid"},   bus.core_din_valid, 0);
        check({tag, "_last_block"},  bus.core_last_block, 0);
        check({tag, "_core_reset"},  bus.core_reset, 1);
    endtask

    // One full message from the requesters in act; bp_* opens a buffer_full window,
    // wait_len adds WAIT cycles, stall_len holds resp_ready low, abort_after resets mid-FEED.
    task automatic run_msg(input logic [NUM_REQ-1:0] act, input int nwords, input int bp_at,
                           input int bp_len, input int wait_len, input int stall_len,
                           input int abort_after, input bit no_dout);
        logic [IN_BUF_SIZE-1:0]  words[$];
        logic [NUM_REQ-1:0]      exp_rdy;
        logic [DIGEST_WIDTH-1:0] dig;
        logic                    full;
        int g, sent, c, k;

        g = pick(act);
        model_ptr = (g + 1) % NUM_REQ;
        for (int i = 0; i < nwords; i++) words.push_back({$urandom, $urandom});

        @(negedge clock);
        bus.req_valid = act;
        for (int r = 0; r < NUM_REQ; r++) bus.req_din[r] = {$urandom, $urandom};
        bus.req_din[g]  = words[0];
        bus.req_last    = '0;
        bus.req_last[g] = (nwords == 1);
        #1;
        check("idle_ready", bus.req_ready, '0);
        check("idle_core_reset", bus.core_reset, 0);

        sent = 0;
        c    = 0;
        while (sent < nwords && c < nwords + bp_len + 8) begin
            @(negedge clock);
            full = (c >= bp_at) && (c < bp_at + bp_len);
            bus.core_buffer_full = full;
            bus.req_din[g]  = words[sent];
            bus.req_last[g] = (sent == nwords - 1);
            #1;
            exp_rdy = '0;
            if (!full) exp_rdy[g] = 1'b1;
            check("feed_ready", bus.req_ready, exp_rdy);
            check("feed_din_valid", bus.core_din_valid, !full);
            if (!full) begin
                check("feed_din", bus.core_din, words[sent]);
                sent++;
            end
            c++;
            if (abort_after >= 0 && sent == abort_after) begin
                @(negedge clock);
                reset_n       = 1'b0;
                bus.req_valid = '0;
                bus.req_last  = '0;
                #1;
                check_reset_outputs("abort");
                repeat (2) @(negedge clock);
                reset_n   = 1'b1;
                model_ptr = 0;
                repeat (3) begin
                    @(negedge clock);
                    #1;
                    check("post_abort_resp_valid", bus.resp_valid, 0);
                    check("post_abort_core_reset", bus.core_reset, 0);
                end
                return;
            end
        end
        check("feed_words", sent, nwords);

        @(negedge clock);
        bus.core_buffer_full = 1'b0;
        #1;
        check("last_block", bus.core_last_block, 1);
        check("last_din_valid", bus.core_din_valid, 0);
        check("last_ready", bus.req_ready, '0);

        if (no_dout) begin
            k = 0;
            while (k < 100) begin
                @(negedge clock);
                #1;
                if (bus.resp_valid) break;
                k++;
            end
            check("timeout_latency", k, TO);
            dig = '0;
        end else begin
            // Digest offered while the core is not ready must not be captured.
            for (int i = 0; i < wait_len; i++) begin
                @(negedge clock);
                bus.core_ready      = 1'b0;
                bus.core_dout_valid = 1'b1;
                bus.core_dout       = {8{$urandom}};
                #1;
                check("wait_last_block", bus.core_last_block, 0);
                check("wait_resp_valid", bus.resp_valid, 0);
            end
            @(negedge clock);
            dig = {8{$urandom}};
            bus.core_ready      = 1'b1;
            bus.core_dout_valid = 1'b1;
            bus.core_dout       = dig;
            #1;
            check("capture_resp_valid", bus.resp_valid, 0);
            @(negedge clock);
            bus.core_dout_valid = 1'b0;
            bus.core_dout       = {8{$urandom}};
            #1;
        end

        check("resp_valid", bus.resp_valid, 1);
        check("resp_digest", bus.resp_digest, dig);
        check("resp_id", bus.resp_id, g);
        check("resp_err", bus.resp_err, no_dout);
        for (int i = 0; i < stall_len; i++) begin
            @(negedge clock);
            #1;
            check("stall_resp_valid", bus.resp_valid, 1);
            check("stall_resp_digest", bus.resp_digest, dig);
            check("stall_resp_id", bus.resp_id, g);
            check("stall_req_ready", bus.req_ready, '0);
            check("stall_core_reset", bus.core_reset, 0);
        end
        @(negedge clock);
        bus.resp_ready = 1'b1;
        #1;
        check("hs_resp_valid", bus.resp_valid, 1);
        @(negedge clock);
        bus.resp_ready = 1'b0;
        #1;
        check("clr_core_reset", bus.core_reset, 1);
        check("clr_resp_valid", bus.resp_valid, 0);
        check("clr_req_ready", bus.req_ready, '0);
    endtask

    initial begin
        idle_inputs();
        #2 reset_n = 1'b0;
        @(negedge clock);
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("release_core_reset", bus.core_reset, 0);

        // Single three-word message from requester 0.
        run_msg(2'b01, 3, 99, 0, 2, 0, -1, 1'b0);
        // Both requesters hold valid: grants alternate.
        repeat (4) run_msg(2'b11, $urandom_range(1, 4), 99, 0, $urandom_range(0, 2), 0, -1, 1'b0);
        // Buffer full for five cycles mid-message.
        run_msg(2'b11, 6, 2, 5, 1, 0, -1, 1'b0);
        // Consumer stalls ten cycles with a competing request pending.
        run_msg(2'b11, 2, 99, 0, 0, 10, -1, 1'b0);
        // Reset after word 2, then arbitration restarts from requester 0.
        run_msg(2'b01, 5, 99, 0, 0, 0, 2, 1'b0);
        run_msg(2'b11, 2, 99, 0, 0, 0, -1, 1'b0);
        // Random mix of requesters, lengths and backpressure.
        repeat (6) run_msg(NUM_REQ'($urandom_range(1, 3)), $urandom_range(1, 5),
                           $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 4), -1, 1'b0);
`ifdef KECCAK_ARB_TIMEOUT_EN
        run_msg(2'b01, 1, 99, 0, 0, 0, -1, 1'b1);
`endif
        idle_inputs();
        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
